// File: rtl/toy_mem_dma.sv
// toy_mem_dma: block-copy initiator on a single SRAM-style memory port.
// Copies len words from src_addr to dst_addr, one read plus one write per word.
// The read has 1-cycle latency, so the write data comes straight from mem_rd_data.
// Optional build macro TOY_DMA_FILL_EN adds a fill mode. In fill mode a latched
// pattern is written to consecutive destination words at one word per cycle.
module toy_mem_dma #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   src_addr,
    input  logic [ADDR_WIDTH-1:0]   dst_addr,
    input  logic [LEN_WIDTH-1:0]    len,
    input  logic                    abort,
`ifdef TOY_DMA_FILL_EN
    input  logic                    fill,
    input  logic [DATA_WIDTH-1:0]   fill_pattern,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [LEN_WIDTH-1:0]    words_done,
    output logic                    mem_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_rd_data,
    output logic [DATA_WIDTH-1:0]   mem_wr_data,
    output logic [DATA_WIDTH/8-1:0] mem_wr_byte_en,
    output logic                    mem_wr_en
);

    localparam int unsigned Bytes = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] Step      = ADDR_WIDTH'(Bytes);
    localparam logic [ADDR_WIDTH-1:0] AlignMask = ~(ADDR_WIDTH'(Bytes - 1));
    localparam logic [LEN_WIDTH-1:0]  LenOne    = LEN_WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StFin} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic [LEN_WIDTH-1:0]  words_done_q;
    // Abort seen during RD; the pending write still happens, then the transfer ends.
    logic                  abort_q;
    logic                  start_fill;
    logic                  fill_mode;
    logic [DATA_WIDTH-1:0] wr_data_sel;

`ifdef TOY_DMA_FILL_EN
    logic                  fill_q;
    logic [DATA_WIDTH-1:0] pattern_q;

    assign start_fill  = fill;
    assign fill_mode   = fill_q;
    assign wr_data_sel = fill_q ? pattern_q : mem_rd_data;
`else
    assign start_fill  = 1'b0;
    assign fill_mode   = 1'b0;
    assign wr_data_sel = mem_rd_data;
`endif

    // Transfer FSM: pointer, counter and state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            src_q        <= '0;
            dst_q        <= '0;
            rem_q        <= '0;
            words_done_q <= '0;
            abort_q      <= 1'b0;
`ifdef TOY_DMA_FILL_EN
            fill_q       <= 1'b0;
            pattern_q    <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        src_q        <= src_addr & AlignMask;
                        dst_q        <= dst_addr & AlignMask;
                        rem_q        <= len;
                        words_done_q <= '0;
                        abort_q      <= 1'b0;
`ifdef TOY_DMA_FILL_EN
                        fill_q       <= fill;
                        pattern_q    <= fill_pattern;
`endif
                        if (len == '0) begin
                            state_q <= StFin;
                        end else if (start_fill) begin
                            state_q <= StWr;
                        end else begin
                            state_q <= StRd;
                        end
                    end
                end
                StRd: begin
                    if (abort) begin
                        abort_q <= 1'b1;
                    end
                    state_q <= StWr;
                end
                StWr: begin
                    src_q        <= src_q + Step;
                    dst_q        <= dst_q + Step;
                    rem_q        <= rem_q - LenOne;
                    words_done_q <= words_done_q + LenOne;
                    if (rem_q == LenOne || abort || abort_q) begin
                        state_q <= StFin;
                    end else if (fill_mode) begin
                        state_q <= StWr;
                    end else begin
                        state_q <= StRd;
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy       = (state_q == StRd) || (state_q == StWr);
        done       = (state_q == StFin);
        words_done = words_done_q;
    end

    // Memory port: driven only in RD and WR, zero otherwise.
    always_comb begin
        mem_en         = 1'b0;
        mem_wr_en      = 1'b0;
        mem_addr       = '0;
        mem_wr_data    = '0;
        mem_wr_byte_en = '0;
        unique case (state_q)
            StRd: begin
                mem_en   = 1'b1;
                mem_addr = src_q;
            end
            StWr: begin
                mem_en         = 1'b1;
                mem_wr_en      = 1'b1;
                mem_addr       = dst_q;
                mem_wr_data    = wr_data_sel;
                mem_wr_byte_en = '1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/toy_mem_dma.md
Name: toy_mem_dma

Overview:
Memory-port initiator that copies a block of words from a source to a destination address on a single SRAM-style port. The port is the same en/addr/wr_data/wr_byte_en/wr_en/rd_data protocol that toy_mem_model responds to, with a registered read of 1-cycle latency. The block sits beside the core in toy_soc and drives a memory-model instance or a bus-mux slave port. Its uses are preloading data TCM, testbench-side block moves, and exercising the memory responder from the initiator side.

Parameters:
ADDR_WIDTH, 32, byte-address width of the memory port
DATA_WIDTH, 32, memory word width; a multiple of 8
LEN_WIDTH, 16, width of the word-count field

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  single-cycle request; src_addr/dst_addr/len are sampled on it
src_addr  input  ADDR_WIDTH  source byte address; low log2(DATA_WIDTH/8) bits ignored
dst_addr  input  ADDR_WIDTH  destination byte address; low bits ignored
len  input  LEN_WIDTH  number of words to copy
abort  input  1  stop the transfer after the current word
busy  output  1  transfer in progress
done  output  1  one-cycle pulse when the transfer ends (normal end or abort)
words_done  output  LEN_WIDTH  words written in the current or last transfer
mem_en  output  1  memory access enable
mem_addr  output  ADDR_WIDTH  memory byte address
mem_rd_data  input  DATA_WIDTH  read data, valid the cycle after a read access
mem_wr_data  output  DATA_WIDTH  write data
mem_wr_byte_en  output  DATA_WIDTH/8  byte enables
mem_wr_en  output  1  write strobe, qualified by mem_en

Behaviour:
- Reset values: busy=0, done=0, words_done=0, mem_en=0, mem_wr_en=0, mem_addr=0, mem_wr_byte_en=0, mem_wr_data=0. The FSM is in IDLE.
- An asynchronous reset mid-transfer returns to IDLE immediately. No further memory access occurs and done is not pulsed.
- FSM states: IDLE, RD, WR, FIN.
- IDLE:
  - On start: latch word-aligned src/dst pointers and a remaining counter = len; clear words_done.
  - len!=0: go to RD. len==0: go to FIN with no memory access.
  - start is ignored while busy=1.
- RD: mem_en=1, mem_wr_en=0, mem_addr=src pointer. Go to WR.
- WR:
  - Drive mem_en=1, mem_wr_en=1, mem_addr=dst pointer, mem_wr_data=mem_rd_data (combinational pass-through), mem_wr_byte_en=all ones.
  - Advance both pointers by DATA_WIDTH/8, decrement remaining, increment words_done.
  - remaining becomes 0, or abort is sampled high in RD or WR: go to FIN. Otherwise go to RD.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- busy=1 in RD and WR. busy is high from the cycle after start until FIN.
- Throughput: 2 cycles per word. Latency from start to done for N words is 2N+1 cycles.
- Pointer arithmetic wraps modulo 2^ADDR_WIDTH; no error is raised on wrap.
- Memory outputs are combinational from the state and pointer registers. mem_en=0 in IDLE and FIN. In those states mem_addr, mem_wr_data and mem_wr_byte_en are held at 0.
- abort in IDLE has no effect. abort during RD still completes that word's write; the transfer then ends.
- Overlapping src/dst ranges: plain ascending copy, no hazard protection.

Optional Feature:
TOY_DMA_FILL_EN
- Defined:
  - Adds ports fill (input, 1, sampled with start) and fill_pattern (input, DATA_WIDTH, sampled with start).
  - With fill=1, the FSM skips RD and stays in WR. It writes the latched pattern to consecutive dst words at 1 word/cycle. src_addr is ignored.
  - Start-to-done latency for N words is N+1 cycles.
- Undefined: the ports do not exist; copy mode only.

Test Plan:
- Preload words 0x11111111..0x44444444 at 0x100; start src=0x100, dst=0x200, len=4 -> 0x200..0x20C hold the same words; done pulses 9 cycles after start; words_done=4.
- start with len=0 -> done pulses the next cycle; mem_en never asserted; words_done=0.
- len=8, abort asserted in the 3rd RD -> exactly 3 words written; done pulse; words_done=3; busy=0.
- src=0xFFFFFFF8, len=4 -> reads 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 (wrap-around); src=0x103 aligned to 0x100.
- Second start during busy with different len -> ignored; the original transfer completes unchanged. Assert rst_n low mid-transfer -> mem_en=0 immediately, no done.
- TOY_DMA_FILL_EN: fill=1, pattern=0xDEADBEEF, dst=0x300, len=5 -> 5 consecutive write cycles, no read access, done 6 cycles after start.
